flash_loader: RTL and testbench
===============================

# flash_loader

Boot-time program loader that copies a fixed-length image from the board's parallel flash into main RAM. It sits directly upstream of the RAM address/data selector and drives that selector's `initializing`, `init_addr` and `init_data` inputs. It also drives the RAM write strobe while loading. Once the last word is written, it releases `initializing` so the selector hands the RAM bus to the execute stage.

## Interface
Parameters:
- `WORDS`, default 512: number of 16-bit words copied; legal range 1..65535.
- `READ_WAIT`, default 4: cycles `flash_oe_n` is held low per read; minimum 1.
- `WRITE_WAIT`, default 2: cycles `ram_we_n` is held low per write; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `flash_data`  in  `RegValue`  flash read data.
- `flash_addr`  out  22  flash word address, `{6'b0, word_idx}`.
- `flash_ce_n`  out  1  flash chip enable, active-low.
- `flash_oe_n`  out  1  flash output enable, active-low.
- `initializing`  out  1  high while loading; feeds the selector.
- `init_addr`  out  `RegValue`  RAM write address.
- `init_data`  out  `RegValue`  RAM write data.
- `ram_we_n`  out  1  RAM write strobe, active-low.
- `done`  out  1  high once the image is fully loaded.
- `checksum`  out  `RegValue`  see Configuration.

## Operation
Reset values:
- `initializing`=1, `done`=0.
- `init_addr`=0, `init_data`=0, `checksum`=0.
- `ram_we_n`=1, `flash_oe_n`=1, `flash_ce_n`=1.
- `word_idx`=0, state=S_READ.

States:
- S_READ: `flash_ce_n`=0 and `flash_oe_n`=0 for READ_WAIT cycles. On the last cycle's edge, latch `flash_data` into `init_data` and go to S_SETUP.
- S_SETUP: one cycle; `flash_oe_n`=1 and `ram_we_n`=1. `init_addr`=`word_idx` and `init_data` are stable.
- S_WE: `ram_we_n`=0 for WRITE_WAIT cycles.
- S_HOLD: one cycle with `ram_we_n`=1 and address/data unchanged.
  - If `word_idx`==WORDS-1, go to S_DONE.
  - Otherwise increment `word_idx` and go to S_READ.
- S_DONE: terminal until reset.
  - `initializing`=0, `done`=1, `flash_ce_n`=1, `ram_we_n`=1.
  - `init_addr` and `init_data` hold their last values.

Other rules:
- `initializing` and `done` change on the same edge: leaving S_HOLD for S_DONE.
- `word_idx` is 16 bits and never wraps, because WORDS ≤ 65535.
- Changes on `flash_data` outside the latch edge are ignored.

## Timing
- Cycles per word: READ_WAIT + WRITE_WAIT + 2. With defaults this is 8.
- Total load latency after reset release: WORDS × (READ_WAIT + WRITE_WAIT + 2). With defaults this is 4096 cycles.
- `init_addr` and `init_data` are stable from S_SETUP through S_HOLD. This gives one cycle of setup and one cycle of hold around the low strobe.
- `ram_we_n` is never low in the same cycle as `flash_oe_n`.
- Reset asserted mid-operation forces all outputs to their reset values immediately and asynchronously, including `ram_we_n` high. After release, loading restarts from word 0.

## Configuration
Macro: `FLASH_LOADER_CHECKSUM_EN`.
- Defined: `checksum` accumulates the modulo-2^16 sum of every word written, updated on the S_HOLD edge. After `done`, it holds the final sum until reset.
- Undefined: `checksum` is tied to 0 and no adder is built.

## Structure
- Shared header `define.v` holds:
  - `RegValue`;
  - a new `FlashAddr` (21:0) width macro;
  - `LOADER_WORDS` as the system-level default for WORDS.
- State encodings are localparams inside the block.
- One sub-module, `loader_wait_cnt`: a loadable down-counter with a zero flag. It is shared by the S_READ and S_WE dwell timing.

## Test plan
- Basic load: WORDS=4, READ_WAIT=2, WRITE_WAIT=1, flash model returns 16'hA000+address.
  - Four `ram_we_n` pulses at `init_addr` 0..3 with data A000..A003.
  - `done` rises and `initializing` falls together 20 cycles after reset release.
- Strobe timing, default parameters: on every word, `init_addr`/`init_data` are unchanged from one cycle before `ram_we_n` falls to one cycle after it rises. `flash_oe_n` and `ram_we_n` are never both low.
- Reset mid-load: assert `rst` during word 2's S_WE.
  - `ram_we_n` goes high with no clock edge.
  - After release, the first write is again at address 0.
- Post-done stability: after `done`, toggle `flash_data` for 100 cycles → no `ram_we_n` pulse, no change on `init_addr`, `init_data` or `flash_oe_n`.
- Checksum with `FLASH_LOADER_CHECKSUM_EN` defined: WORDS=4, data 0001, 0002, 0003, FFFF → `checksum`=16'h0005 at `done`. With the macro undefined, `checksum` stays 0.
- Boundary WORDS=1: exactly one write at address 0, then S_DONE after READ_WAIT+WRITE_WAIT+2 cycles.

Source files
------------

// File: rtl/flash_loader_pkg.sv
// Shared widths and system-level defaults for the boot loader and its RAM/flash neighbours.
package flash_loader_pkg;
    localparam int REG_W        = 16;
    localparam int FLASH_ADDR_W = 22;
    localparam int IDX_W        = 16;
    localparam int LOADER_WORDS = 512;

    typedef logic [REG_W-1:0] reg_value_t;
endpackage

// File: rtl/flash_loader_wait_cnt.sv
// Loadable down-counter with zero flag, timing the flash read and RAM write dwells.
// Latency: zero reflects the registered count; no backpressure, load wins over dec.
// Saturates at zero so a stray dec can never wrap.
module loader_wait_cnt #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/flash_loader.sv
// Boot loader copying WORDS flash words into RAM; FLASH_LOADER_CHECKSUM_EN adds a running sum.
// Latency: READ_WAIT + WRITE_WAIT + 2 cycles per word, WORDS of them before done.
// No backpressure: flash and RAM are assumed ready within the fixed wait windows.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned WORDS      = LOADER_WORDS,
    parameter int unsigned READ_WAIT  = 4,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  reg_value_t              flash_data,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    output logic                    flash_ce_n,
    output logic                    flash_oe_n,
    output logic                    initializing,
    output reg_value_t              init_addr,
    output reg_value_t              init_data,
    output logic                    ram_we_n,
    output logic                    done,
    output reg_value_t              checksum
);
    localparam logic [2:0] S_READ  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WE    = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] RD_LOAD  = IDX_W'(READ_WAIT - 1);
    localparam logic [IDX_W-1:0] WR_LOAD  = IDX_W'(WRITE_WAIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    reg_value_t       init_data_q, init_data_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [IDX_W-1:0] cnt_val;

    // Counter resets to the read dwell so the first word starts without an extra cycle.
    loader_wait_cnt #(.W(IDX_W), .RST_VAL(RD_LOAD)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_READ;
            word_idx_q  <= '0;
            init_data_q <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            init_data_q <= init_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        init_data_d = init_data_q;
        cnt_load    = 1'b0;
        cnt_val     = RD_LOAD;
        cnt_dec     = 1'b0;
        case (state_q)
            S_READ: begin
                if (cnt_zero) begin
                    init_data_d = flash_data;
                    state_d     = S_SETUP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SETUP: begin
                cnt_load = 1'b1;
                cnt_val  = WR_LOAD;
                state_d  = S_WE;
            end
            S_WE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_HOLD: begin
                if (word_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = RD_LOAD;
                    state_d    = S_READ;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_READ;
        endcase
    end

    always_comb begin
        flash_ce_n   = 1'b0;
        flash_oe_n   = 1'b1;
        ram_we_n     = 1'b1;
        initializing = 1'b1;
        done         = 1'b0;
        case (state_q)
            S_READ: flash_oe_n = 1'b0;
            S_WE:   ram_we_n   = 1'b0;
            S_DONE: begin
                flash_ce_n   = 1'b1;
                initializing = 1'b0;
                done         = 1'b1;
            end
            default: ;
        endcase
        // Reset state decodes as S_READ, so the flash enables are forced off while rst is low.
        if (!rst) begin
            flash_ce_n = 1'b1;
            flash_oe_n = 1'b1;
        end
    end

    assign flash_addr = {{(FLASH_ADDR_W-IDX_W){1'b0}}, word_idx_q};
    assign init_addr  = word_idx_q;
    assign init_data  = init_data_q;

`ifdef FLASH_LOADER_CHECKSUM_EN
    reg_value_t checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_HOLD) begin
            checksum_d = checksum_q + init_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: small, default-size and single-word instances driven in turn.
module tb_flash_loader;
    import flash_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst;
    logic [2:0][15:0]  fd, ia, id, cs;
    logic [2:0][21:0]  fa;
    logic [2:0]        ce, oe, ini, we, dn;

    logic              post_a;
    logic [15:0]       junk;
    logic [15:0]       mem_b [0:511];
    logic [15:0]       mem_c;

    assign fd[0] = post_a ? junk : (16'hA000 + fa[0][15:0]);
    assign fd[1] = mem_b[fa[1][8:0]];
    assign fd[2] = mem_c;

    flash_loader #(.WORDS(4), .READ_WAIT(2), .WRITE_WAIT(1)) u_a (
        .clk(clk), .rst(rst[0]), .flash_data(fd[0]), .flash_addr(fa[0]),
        .flash_ce_n(ce[0]), .flash_oe_n(oe[0]), .initializing(ini[0]),
        .init_addr(ia[0]), .init_data(id[0]), .ram_we_n(we[0]),
        .done(dn[0]), .checksum(cs[0]));

    flash_loader u_b (
        .clk(clk), .rst(rst[1]), .flash_data(fd[1]), .flash_addr(fa[1]),
        .flash_ce_n(ce[1]), .flash_oe_n(oe[1]), .initializing(ini[1]),
        .init_addr(ia[1]), .init_data(id[1]), .ram_we_n(we[1]),
        .done(dn[1]), .checksum(cs[1]));

    flash_loader #(.WORDS(1), .READ_WAIT(3), .WRITE_WAIT(2)) u_c (
        .clk(clk), .rst(rst[2]), .flash_data(fd[2]), .flash_addr(fa[2]),
        .flash_ce_n(ce[2]), .flash_oe_n(oe[2]), .initializing(ini[2]),
        .init_addr(ia[2]), .init_data(id[2]), .ram_we_n(we[2]),
        .done(dn[2]), .checksum(cs[2]));

    // Bus monitor: logs every RAM write and tallies protocol violations per instance.
    int               wcnt  [3] = '{0, 0, 0};
    int               stab  [3] = '{0, 0, 0};
    int               ovl   [3] = '{0, 0, 0};
    int               addrv [3] = '{0, 0, 0};
    int               tog   [3] = '{0, 0, 0};
    logic [31:0]      wlog  [3][0:1023];
    logic [2:0]       pwe = 3'b111;
    logic [2:0][15:0] pia, pid, ria, rid;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst[k]) begin
                pwe[k] <= 1'b1;
            end else begin
                if (!we[k] && !oe[k]) ovl[k] <= ovl[k] + 1;
                if (fa[k] !== {6'b0, ia[k]}) addrv[k] <= addrv[k] + 1;
                if (ini[k] === dn[k]) tog[k] <= tog[k] + 1;
                if (!we[k] && pwe[k]) begin
                    if (ia[k] !== pia[k] || id[k] !== pid[k]) stab[k] <= stab[k] + 1;
                    if (wcnt[k] < 1024) wlog[k][wcnt[k]] <= {ia[k], id[k]};
                    wcnt[k] <= wcnt[k] + 1;
                    ria[k]  <= ia[k];
                    rid[k]  <= id[k];
                end else if (!pwe[k]) begin
                    if (ia[k] !== ria[k] || id[k] !== rid[k]) stab[k] <= stab[k] + 1;
                end
                pwe[k] <= we[k];
                pia[k] <= ia[k];
                pid[k] <= id[k];
            end
        end
    end

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k, input int budget, output int cyc);
        cyc = 0;
        while (dn[k] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef FLASH_LOADER_CHECKSUM_EN
        return s;
`else
        return (s & 16'h0000);
`endif
    endfunction

    initial begin
        int          cyc, base, bad, chg;
        logic [15:0] sum, sa, sd;
        logic        so;
        int          sw;

        rst    = 3'b000;
        post_a = 1'b0;
        junk   = '0;
        for (int i = 0; i < 512; i++) mem_b[i] = 16'($urandom);
        mem_c = 16'($urandom);
        repeat (3) @(negedge clk);

        chk("rst_initializing", ini[0], 1);
        chk("rst_done", dn[0], 0);
        chk("rst_init_addr", ia[0], 0);
        chk("rst_init_data", id[0], 0);
        chk("rst_checksum", cs[0], 0);
        chk("rst_ram_we_n", we[0], 1);
        chk("rst_flash_oe_n", oe[0], 1);
        chk("rst_flash_ce_n", ce[0], 1);

        // Instance A: four words, data A000+address, 5 cycles per word.
        rst[0] = 1'b1;
        wait_done(0, 200, cyc);
        chk("a_done_latency", cyc, 20);
        chk("a_initializing_low", ini[0], 0);
        chk("a_write_count", wcnt[0], 4);
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_write%0d", i), wlog[0][i], {16'(i), 16'hA000 + 16'(i)});
            sum = sum + 16'hA000 + 16'(i);
        end
        chk("a_checksum", cs[0], exp_sum(sum));

        sa = ia[0]; sd = id[0]; so = oe[0]; sw = wcnt[0]; chg = 0;
        post_a = 1'b1;
        repeat (100) begin
            junk = 16'($urandom);
            @(negedge clk);
            if (ia[0] !== sa || id[0] !== sd || oe[0] !== so || we[0] !== 1'b1 || dn[0] !== 1'b1) chg++;
        end
        chk("a_post_done_changes", chg, 0);
        chk("a_post_done_writes", wcnt[0], sw);

        // Instance B: default sizing, random image, reset during word 2's write strobe.
        rst[1] = 1'b1;
        cyc = 0;
        while (!(we[1] === 1'b0 && ia[1] === 16'd2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_word2_we_cycle", cyc, 21);
        #2 rst[1] = 1'b0;
        #1;
        chk("b_async_ram_we_n", we[1], 1);
        chk("b_async_flash_oe_n", oe[1], 1);
        chk("b_async_flash_ce_n", ce[1], 1);
        chk("b_async_init_addr", ia[1], 0);
        chk("b_async_initializing", ini[1], 1);
        @(negedge clk);
        @(negedge clk);
        base = wcnt[1];
        rst[1] = 1'b1;
        wait_done(1, 5000, cyc);
        chk("b_done_latency", cyc, LOADER_WORDS * 8);
        chk("b_write_count", wcnt[1] - base, LOADER_WORDS);
        chk("b_first_addr", {16'h0, wlog[1][base][31:16]}, 0);
        bad = 0;
        sum = '0;
        for (int i = 0; i < 512; i++) begin
            if (wlog[1][base + i] !== {16'(i), mem_b[i]}) bad++;
            sum = sum + mem_b[i];
        end
        chk("b_image_mismatches", bad, 0);
        chk("b_checksum", cs[1], exp_sum(sum));

        // Instance C: single word boundary.
        rst[2] = 1'b1;
        wait_done(2, 100, cyc);
        chk("c_done_latency", cyc, 7);
        chk("c_write_count", wcnt[2], 1);
        chk("c_write0", wlog[2][0], {16'h0, mem_c});
        chk("c_checksum", cs[2], exp_sum(mem_c));

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stability_%0d", k), stab[k], 0);
            chk($sformatf("oe_we_overlap_%0d", k), ovl[k], 0);
            chk($sformatf("flash_addr_%0d", k), addrv[k], 0);
            chk($sformatf("init_done_together_%0d", k), tog[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
